// File: rtl/gmsk_v1_obi_responder.sv
// ---------------------------------------------------------------------------
// gmsk_v1_obi_responder
//
// Memory-side OBI responder for the GMSK-V1 core's data port. It accepts
// load/store requests, optionally holds off the grant for WAIT_CYCLES idle
// cycles, and returns in-order read data on the cycle after each grant. It is
// backed by a word-addressed local RAM that reset does not clear.
//
// Optional feature macro: GMSK_V1_OBI_TOHOST_EN
//   When defined, a single word at TOHOST_ADDR is decoded as a tohost
//   register. Writing a nonzero value to it raises halt_o. When undefined,
//   TOHOST_ADDR is ordinary address space, and halt_o/tohost_o are tied to 0.
//
// Parameters:
//   MEM_WORDS    RAM depth in 32-bit words (power of two)
//   BASE_ADDR    byte address of word 0
//   WAIT_CYCLES  idle cycles inserted before each grant (0..15)
//   TOHOST_ADDR  byte address of the tohost register
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   data_req_i     request valid
//   data_gnt_o     request accepted this cycle
//   data_addr_i    byte address (bits [1:0] ignored)
//   data_we_i      1 = store, 0 = load
//   data_be_i      byte enables for stores
//   data_wdata_i   store data
//   data_rvalid_o  response valid (cycle after grant)
//   data_rdata_o   load data (0 for stores and when no response)
//   err_o          sticky out-of-range access flag
//   halt_o         tohost written with a nonzero value
//   tohost_o       last tohost value written
// ---------------------------------------------------------------------------
module gmsk_v1_obi_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        err_o,
  output logic        halt_o,
  output logic [31:0] tohost_o
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] OOR_DATA  = 32'hDEAD_BEEF;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_fsm;
  logic        gnt;

  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] word_idx;
  logic        is_tohost;
  logic        mem_we;
  logic [31:0] rd_word;
  logic [31:0] resp_data;

  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        halt_q;
  logic [31:0] tohost_q;

  logic [31:0] mem [MEM_WORDS];

  // -------------------------------------------------------------------------
  // Address decode. The subtraction wraps, so addresses below BASE_ADDR land
  // far above MEM_BYTES and fall out of range naturally.
  // -------------------------------------------------------------------------
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = ({1'b0, offset} < MEM_BYTES);
  assign word_idx = offset[AW+1:2];

  // Byte-offset bits and the bits above the RAM index carry no information
  // once in_range has been computed.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[1:0], offset[31:AW+2]};

`ifdef GMSK_V1_OBI_TOHOST_EN
  assign is_tohost = (data_addr_i == TOHOST_ADDR);
`else
  assign is_tohost = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Grant FSM
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_fsm = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (WAIT_CYCLES == 0) begin
          gnt_fsm = data_req_i;
        end else if (data_req_i) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (!data_req_i) begin
          // Request withdrawn before grant: abandon it without a grant.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          gnt_fsm = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // In the zero-wait configuration the grant is a combinational echo of the
  // request, so it is masked during reset to keep every output low and to
  // block RAM writes while reset is held.
  assign gnt        = gnt_fsm & ~rst;
  assign data_gnt_o = gnt;

  // -------------------------------------------------------------------------
  // RAM
  // -------------------------------------------------------------------------
  assign mem_we  = gnt & data_we_i & in_range & ~is_tohost;
  assign rd_word = mem[word_idx];

  // NOTE: the RAM array has no reset; its contents survive reset and may be
  // preloaded by a bench, and omitting the reset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) begin
          mem[word_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response payload captured at the grant edge. Stores answer with zero.
  always_comb begin
    resp_data = '0;
    if (!data_we_i) begin
      if (is_tohost) begin
        resp_data = tohost_q;
      end else if (in_range) begin
        resp_data = rd_word;
      end else begin
        resp_data = OOR_DATA;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State, response and error registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt;
      rdata_q  <= gnt ? resp_data : '0;
      if (gnt && !in_range && !is_tohost) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef GMSK_V1_OBI_TOHOST_EN
  // tohost takes the full word regardless of byte enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_q <= '0;
      halt_q   <= 1'b0;
    end else if (gnt && is_tohost && data_we_i) begin
      tohost_q <= data_wdata_i;
      if (data_wdata_i != 32'd0) begin
        halt_q <= 1'b1;
      end
    end
  end
`else
  assign tohost_q = '0;
  assign halt_q   = 1'b0;
`endif

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign err_o         = err_q;
  assign halt_o        = halt_q;
  assign tohost_o      = tohost_q;

endmodule

// File: tb/tb_gmsk_v1_obi_responder.sv
// ---------------------------------------------------------------------------
// Testbench for gmsk_v1_obi_responder.
// dut0 runs with WAIT_CYCLES=0 and is checked by a scoreboard monitor that
// expects each response on the cycle after its grant. dut3 runs with
// WAIT_CYCLES=3 for grant-latency and back-to-back spacing checks.
// ---------------------------------------------------------------------------
module tb_gmsk_v1_obi_responder;

`ifdef GMSK_V1_OBI_TOHOST_EN
  localparam bit TOHOST_EN = 1'b1;
`else
  localparam bit TOHOST_EN = 1'b0;
`endif

  localparam logic [31:0] OOR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0 (zero wait)
  logic        req0, gnt0, we0, rvalid0, err0, halt0;
  logic [31:0] addr0, wdata0, rdata0, tohost0;
  logic [3:0]  be0;
  // dut3 (three wait cycles)
  logic        req3, gnt3, we3, rvalid3, err3, halt3;
  logic [31:0] addr3, wdata3, rdata3, tohost3;
  logic [3:0]  be3;

  gmsk_v1_obi_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .data_req_i(req0), .data_gnt_o(gnt0), .data_addr_i(addr0),
    .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0),
    .data_rvalid_o(rvalid0), .data_rdata_o(rdata0),
    .err_o(err0), .halt_o(halt0), .tohost_o(tohost0)
  );

  gmsk_v1_obi_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .data_req_i(req3), .data_gnt_o(gnt3), .data_addr_i(addr3),
    .data_we_i(we3), .data_be_i(be3), .data_wdata_i(wdata3),
    .data_rvalid_o(rvalid3), .data_rdata_o(rdata3),
    .err_o(err3), .halt_o(halt3), .tohost_o(tohost3)
  );

  int vecs = 0;
  int misc = 0;
  int cyc  = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for dut0: a response is due exactly one cycle after
  // the grant it belongs to; in every other cycle rvalid and rdata are 0.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        check("rvalid0", 32'(rvalid0), 32'd1);
        check("rdata0", rdata0, sb[0].data);
        void'(sb.pop_front());
      end else begin
        check("rvalid0_idle", 32'(rvalid0), 32'd0);
        check("rdata0_idle", rdata0, 32'd0);
      end
    end
  end

  // One request cycle on dut0; entered and left just after a rising edge.
  task automatic drive0(input string tag, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp);
    exp_t e;
    req0 = 1'b1; we0 = we; addr0 = a; be0 = be; wdata0 = wd;
    e.data = exp;
    e.due  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    check({tag, "_gnt"}, 32'(gnt0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle0(input int n);
    repeat (n) begin
      req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; wdata0 = '0;
      @(negedge clk);
      check("idle_gnt0", 32'(gnt0), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_pulse();
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstp_err0", 32'(err0), 32'd0);
    check("rstp_halt0", 32'(halt0), 32'd0);
    check("rstp_tohost0", tohost0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // Waits (bounded) for a grant on dut3. k counts cycles from entry to the
  // grant cycle; rv/rd capture dut3's response in the first cycle.
  task automatic wait_gnt3(output int k, output logic rv, output logic [31:0] rd);
    k = 0; rv = 1'b0; rd = '0;
    while (k < 16) begin
      @(negedge clk);
      if (k == 0) begin
        rv = rvalid3;
        rd = rdata3;
      end
      if (gnt3) break;
      @(posedge clk); #1;
      k++;
    end
    if (k < 16) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic        rv;
    logic [31:0] rd;

    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0001_0010; be0 = 4'h0; wdata0 = '0;
    req3 = 1'b0; we3 = 1'b0; addr3 = '0; be3 = 4'h0; wdata3 = '0;
    repeat (2) @(posedge clk); #1;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_halt0", 32'(halt0), 32'd0);
    check("rst_tohost0", tohost0, 32'd0);
    check("rst_gnt3", 32'(gnt3), 32'd0);
    check("rst_rvalid3", 32'(rvalid3), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // ---------------- WAIT_CYCLES=3: latency and spacing ----------------
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h0001_0004; be3 = 4'hF; wdata3 = 32'hCAFE_0001;
    wait_gnt3(k, rv, rd);
    check("w3_store_latency", 32'(k), 32'd3);
    check("w3_no_early_rvalid", 32'(rv), 32'd0);
    we3 = 1'b0; be3 = 4'h0;
    wait_gnt3(k, rv, rd);
    check("w3_ld1_spacing", 32'(k), 32'd3);
    check("w3_store_rvalid", 32'(rv), 32'd1);
    check("w3_store_rdata", rd, 32'd0);
    wait_gnt3(k, rv, rd);
    check("w3_ld2_spacing", 32'(k), 32'd3);
    check("w3_ld1_rvalid", 32'(rv), 32'd1);
    check("w3_ld1_rdata", rd, 32'hCAFE_0001);
    req3 = 1'b0;
    @(negedge clk);
    check("w3_ld2_rvalid", 32'(rvalid3), 32'd1);
    check("w3_ld2_rdata", rdata3, 32'hCAFE_0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("w3_rvalid_drop", 32'(rvalid3), 32'd0);
    @(posedge clk); #1;
    // Request withdrawn in WAIT: no grant, then a fresh request starts over.
    req3 = 1'b1;
    @(negedge clk);
    check("w3_abort_gnt_a", 32'(gnt3), 32'd0);
    @(posedge clk); #1;
    req3 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("w3_abort_gnt_b", 32'(gnt3), 32'd0);
      @(posedge clk); #1;
    end
    req3 = 1'b1;
    wait_gnt3(k, rv, rd);
    check("w3_after_abort_latency", 32'(k), 32'd3);
    req3 = 1'b0;
    @(negedge clk);
    check("w3_after_abort_rdata", rdata3, 32'hCAFE_0001);
    @(posedge clk); #1;

    // ---------------- WAIT_CYCLES=0: basic store/load ----------------
    drive0("st_basic", 1'b1, 32'h0001_0010, 4'hF, 32'h1234_5678, 32'd0);
    idle0(1);
    drive0("ld_basic", 1'b0, 32'h0001_0010, 4'h0, 32'd0, 32'h1234_5678);
    idle0(1);

    // Byte lanes, back-to-back, load right after store (read-after-write).
    drive0("st_lanes_full", 1'b1, 32'h0001_0020, 4'hF, 32'hAABB_CCDD, 32'd0);
    drive0("st_lanes_part", 1'b1, 32'h0001_0020, 4'b1001, 32'h1100_0022, 32'd0);
    drive0("ld_lanes", 1'b0, 32'h0001_0020, 4'h0, 32'd0, 32'h11BB_CC22);
    drive0("st_raw", 1'b1, 32'h0001_0030, 4'hF, 32'h5A5A_0F0F, 32'd0);
    drive0("ld_raw", 1'b0, 32'h0001_0030, 4'h0, 32'd0, 32'h5A5A_0F0F);
    drive0("ld_lowbits", 1'b0, 32'h0001_0013, 4'h0, 32'd0, 32'h1234_5678);
    // Last word of the RAM.
    drive0("st_last", 1'b1, 32'h0001_0FFC, 4'hF, 32'h0BAD_F00D, 32'd0);
    drive0("ld_last", 1'b0, 32'h0001_0FFC, 4'h0, 32'd0, 32'h0BAD_F00D);
    idle0(1);
    check("err_before_oor", 32'(err0), 32'd0);

    // ---------------- tohost ----------------
    drive0("st_tohost", 1'b1, 32'h0002_0000, 4'hF, 32'h0000_0001, 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    check("tohost_halt", 32'(halt0), TOHOST_EN ? 32'd1 : 32'd0);
    check("tohost_value", tohost0, TOHOST_EN ? 32'd1 : 32'd0);
    check("tohost_err", 32'(err0), TOHOST_EN ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    drive0("ld_tohost", 1'b0, 32'h0002_0000, 4'h0, 32'd0, TOHOST_EN ? 32'd1 : OOR);
    idle0(1);
    reset_pulse();

    // ---------------- out of range ----------------
    drive0("st_word0", 1'b1, 32'h0001_0000, 4'hF, 32'hA5A5_A5A5, 32'd0);
    idle0(1);
    check("err_pre_oor", 32'(err0), 32'd0);
    drive0("ld_oor", 1'b0, 32'h0000_0100, 4'h0, 32'd0, OOR);
    req0 = 1'b0;
    @(negedge clk);
    check("err_after_oor", 32'(err0), 32'd1);
    @(posedge clk); #1;
    idle0(3);
    check("err_sticky", 32'(err0), 32'd1);
    drive0("st_oor", 1'b1, 32'h0003_0000, 4'hF, 32'hFFFF_FFFF, 32'd0);
    drive0("ld_word0", 1'b0, 32'h0001_0000, 4'h0, 32'd0, 32'hA5A5_A5A5);
    drive0("ld_past_end", 1'b0, 32'h0001_1000, 4'h0, 32'd0, OOR);
    idle0(1);

    // ---------------- reset in the cycle after a load grant ----------------
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0001_0010;
    @(negedge clk);
    check("rstmid_gnt", 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    we0 = 1'b1; be0 = 4'hF; wdata0 = 32'h0;
    @(negedge clk);
    check("rstmid_rvalid", 32'(rvalid0), 32'd0);
    check("rstmid_rdata", rdata0, 32'd0);
    check("rstmid_gnt_held", 32'(gnt0), 32'd0);
    check("rstmid_err", 32'(err0), 32'd0);
    check("rstmid_halt", 32'(halt0), 32'd0);
    check("rstmid_tohost", tohost0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'h0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    drive0("ld_after_rst", 1'b0, 32'h0001_0010, 4'h0, 32'd0, 32'h1234_5678);
    idle0(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end

endmodule
